// File: rtl/prg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prg_pkg : shared types and defaults for the primary-ray-generator    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`ifndef VGA_NUM_COLS
`define VGA_NUM_COLS 640
`endif
`ifndef VGA_NUM_ROWS
`define VGA_NUM_ROWS 480
`endif

package prg_pkg;

  localparam int c_def_num_cols = `VGA_NUM_COLS;
  localparam int c_def_num_rows = `VGA_NUM_ROWS;

  typedef enum logic [1:0] {PH_V0 = 2'd0, PH_V1 = 2'd1, PH_V2 = 2'd2} phase_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_V0:   return PH_V1;
      PH_V1:   return PH_V2;
      default: return PH_V0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ff_ar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ff_ar : enabled register with asynchronous active-high reset         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ff_ar #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= RST_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prg_inflight.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prg_inflight : slot-delay line carrying {valid, data}                |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prg_inflight #(
  parameter int DEPTH = 9,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_shift,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_any
);

  logic [W:0]       r_stage [DEPTH];
  logic [DEPTH-1:0] w_vld;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [W:0] w_d;
    if (g == 0) begin : g_head
      assign w_d = {i_valid, i_data};
    end else begin : g_body
      assign w_d = r_stage[g-1];
    end
    ff_ar #(.W(W + 1)) u_ff (
      .clk  (clk),
      .rst  (rst),
      .i_en (i_shift),
      .i_d  (w_d),
      .o_q  (r_stage[g])
    );
    assign w_vld[g] = r_stage[g][W];
  end

  assign o_valid = r_stage[DEPTH-1][W];
  assign o_data  = r_stage[DEPTH-1][W-1:0];
  assign o_any   = |w_vld;

endmodule
`default_nettype wire

// File: rtl/prg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prg_ctrl : PRG sequencer - phase strobes, raster walk, credit issue  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prg_ctrl
  import prg_pkg::*;
#(
  parameter int NUM_COLS = c_def_num_cols,
  parameter int NUM_ROWS = c_def_num_rows,
  parameter int PL_SLOTS = 9,
  parameter int CREDITS  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        ray_deq,
  output logic                        v0,
  output logic                        v1,
  output logic                        v2,
  output logic [$clog2(NUM_COLS)-1:0] x,
  output logic [$clog2(NUM_ROWS)-1:0] y,
  output logic                        ray_valid,
  output logic [$clog2(NUM_COLS)-1:0] ray_x,
  output logic [$clog2(NUM_ROWS)-1:0] ray_y,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        credit_err
);

  localparam int c_xw = $clog2(NUM_COLS);
  localparam int c_yw = $clog2(NUM_ROWS);
  localparam int c_cw = $clog2(CREDITS + 1);
  localparam logic [c_xw-1:0] c_x_last   = c_xw'(NUM_COLS - 1);
  localparam logic [c_yw-1:0] c_y_last   = c_yw'(NUM_ROWS - 1);
  localparam logic [c_cw-1:0] c_cred_max = c_cw'(CREDITS);

  logic [1:0]           r_phase_q, r_state_q;
  phase_t               r_phase, w_phase_d;
  state_t               r_state, w_state_d;
  logic [c_xw-1:0]      r_x, w_x_d, r_ray_x;
  logic [c_yw-1:0]      r_y, w_y_d, r_ray_y;
  logic [c_cw-1:0]      r_cred, w_cred_d;
  logic                 r_issue, r_cred_err, r_ray_valid, r_frame_done;
  logic                 w_is_v0, w_is_v2, w_last_issuing, w_issue_next, w_start_ok;
  logic                 w_xy_en, w_dec, w_full, w_err_set, w_fd_d, w_ray_load;
  logic                 w_inf_vld, w_inf_any;
  logic [c_xw+c_yw-1:0] w_inf_data;

  assign r_phase = phase_t'(r_phase_q);
  assign r_state = state_t'(r_state_q);

  always_comb begin
    w_phase_d      = next_phase(r_phase);
    w_is_v0        = (r_phase == PH_V0);
    w_is_v2        = (r_phase == PH_V2);
    // Block the decision that would re-issue (0,0) right after the last pixel.
    w_last_issuing = r_issue && (r_x == c_x_last) && (r_y == c_y_last);
    w_issue_next   = (r_state == ST_RUN) && (r_cred != '0) && !w_last_issuing;
    w_start_ok     = start && !r_frame_done;
    w_state_d      = r_state;
    w_fd_d         = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_d = ST_RUN;
      ST_RUN:   if (w_is_v2 && w_last_issuing) w_state_d = ST_DRAIN;
      ST_DRAIN: if (!w_inf_any) begin
                  w_state_d = ST_IDLE;
                  w_fd_d    = 1'b1;
                end
      default:  w_state_d = ST_IDLE;
    endcase

    w_xy_en = 1'b0;
    w_x_d   = r_x;
    w_y_d   = r_y;
    if (r_state == ST_IDLE && w_start_ok) begin
      w_xy_en = 1'b1;
      w_x_d   = '0;
      w_y_d   = '0;
    end else if (w_is_v2 && r_issue) begin
      w_xy_en = 1'b1;
      if (r_x == c_x_last) begin
        w_x_d = '0;
        w_y_d = (r_y == c_y_last) ? '0 : r_y + 1'b1;
      end else begin
        w_x_d = r_x + 1'b1;
      end
    end

    w_dec     = w_is_v0 && r_issue;
    w_full    = (r_cred == c_cred_max);
    w_err_set = ray_deq && w_full;
    w_cred_d  = r_cred;
    if (w_dec && !ray_deq) begin
      w_cred_d = r_cred - 1'b1;
    end else if (!w_dec && ray_deq && !w_full) begin
      w_cred_d = r_cred + 1'b1;
    end

    // Registered one cycle early so ray_valid lands on the exit v0 cycle.
    w_ray_load = w_is_v2 && w_inf_vld;
  end

  ff_ar #(.W(2), .RST_VAL(PH_V0)) u_phase (
    .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_phase_d), .o_q(r_phase_q));
  ff_ar #(.W(2), .RST_VAL(ST_IDLE)) u_state (
    .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_state_d), .o_q(r_state_q));
  ff_ar #(.W(c_xw + c_yw)) u_xy (
    .clk(clk), .rst(rst), .i_en(w_xy_en), .i_d({w_x_d, w_y_d}), .o_q({r_x, r_y}));
  ff_ar #(.W(1)) u_issue (
    .clk(clk), .rst(rst), .i_en(w_is_v2), .i_d(w_issue_next), .o_q(r_issue));
  ff_ar #(.W(c_cw), .RST_VAL(c_cred_max)) u_cred (
    .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_cred_d), .o_q(r_cred));
  ff_ar #(.W(1)) u_cred_err (
    .clk(clk), .rst(rst), .i_en(w_err_set), .i_d(1'b1), .o_q(r_cred_err));
  ff_ar #(.W(1)) u_ray_valid (
    .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_ray_load), .o_q(r_ray_valid));
  ff_ar #(.W(c_xw + c_yw)) u_ray_xy (
    .clk(clk), .rst(rst), .i_en(w_ray_load), .i_d(w_inf_data), .o_q({r_ray_x, r_ray_y}));
  ff_ar #(.W(1)) u_frame_done (
    .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_fd_d), .o_q(r_frame_done));

  prg_inflight #(.DEPTH(PL_SLOTS), .W(c_xw + c_yw)) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_is_v0),
    .i_valid (r_issue),
    .i_data  ({r_x, r_y}),
    .o_valid (w_inf_vld),
    .o_data  (w_inf_data),
    .o_any   (w_inf_any)
  );

  assign v0         = (r_phase == PH_V0);
  assign v1         = (r_phase == PH_V1);
  assign v2         = (r_phase == PH_V2);
  assign x          = r_x;
  assign y          = r_y;
  assign ray_valid  = r_ray_valid;
  assign ray_x      = r_ray_x;
  assign ray_y      = r_ray_y;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;
  assign credit_err = r_cred_err;

endmodule
`default_nettype wire

// File: doc/prg_ctrl.md
Name: prg_ctrl

Overview:
- Sequencer for the primary-ray-generator pipeline.
- Generates the free-running one-hot phase strobes v0/v1/v2 and walks pixel coordinates x/y in raster order, issuing one pixel per 3-cycle slot.
- Throttles issue with a credit count against the downstream ray FIFO, because the PRG datapath cannot stall.
- Tracks in-flight slots and emits ray_valid with the matching pixel coordinates when each ray direction completes; pulses frame_done when the frame has fully drained.

Parameters:
- NUM_COLS, 640, pixels per row (x range 0..NUM_COLS-1).
- NUM_ROWS, 480, rows per frame (y range 0..NUM_ROWS-1).
- PL_SLOTS, 9, datapath latency in slots; the ray completes 3*PL_SLOTS cycles after its issue slot's v0 cycle.
- CREDITS, 16, downstream FIFO depth; maximum rays issued but not yet dequeued.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- ray_deq  in  1  downstream consumed one ray; returns one credit
- v0, v1, v2  out  1 each  one-hot phase strobes to the datapath
- x  out  $clog2(NUM_COLS)  pixel column for the current slot
- y  out  $clog2(NUM_ROWS)  pixel row for the current slot
- ray_valid  out  1  one-cycle pulse: datapath output holds a valid ray
- ray_x, ray_y  out  as x, y  coordinates of the ray flagged by ray_valid
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when the frame has drained
- credit_err  out  1  sticky: ray_deq received while credits == CREDITS

Behaviour:
- Reset values: phase = v0 (v0=1, v1=v2=0); x = y = 0; ray_valid = 0; ray_x = ray_y = 0; busy = 0; frame_done = 0; credit_err = 0; credits = CREDITS; in-flight shift register cleared; state = IDLE.
- Reset mid-frame discards all in-flight tracking and the frame; no frame_done is produced.

Phase:
- Rotates v0 -> v1 -> v2 -> v0 every cycle from the first cycle after reset, in every state.
- A slot is one v0, v1, v2 triple.

State machine: IDLE, RUN, DRAIN.
- IDLE -> RUN: start=1 in any cycle. Counters are cleared to x=y=0. The first possible issue is the next slot that begins after the transition.
- start while busy is ignored.

Issue decision:
- Made in the v2 cycle, for the following slot.
- issue_next = (state==RUN) && (credits>0).
- x and y hold the issuing pixel stable for all three cycles of the slot.
- On a non-issue slot, x and y hold their last value and the in-flight bit is 0.

Coordinate advance:
- Happens at the end (v2 edge) of an issuing slot.
- x+1; when x==NUM_COLS-1, x wraps to 0 and y+1.
- On issue of pixel (NUM_COLS-1, NUM_ROWS-1): state -> DRAIN, and x/y wrap to 0.

Credits:
- Decrement on each issue (counted at the slot's v0); increment on ray_deq.
- Issue and deq in the same cycle: count unchanged.
- ray_deq when credits==CREDITS: count unchanged and credit_err set. credit_err clears only on rst.

In-flight tracking:
- PL_SLOTS-deep shift register of {issued, x, y}, shifted once per slot in the v0 cycle.
- When an entry with issued=1 exits: ray_valid=1 for that v0 cycle only, and ray_x/ray_y carry that entry's coordinates.
- ray_x/ray_y hold their value otherwise.

DRAIN -> IDLE:
- Occurs when the shift register holds no issued entries, in the cycle after the last ray_valid.
- frame_done pulses for one cycle on this transition.
- A start in that same cycle is ignored; start is accepted from the next cycle onward.

Decomposition:
- Shared package (existing prg package): `VGA_NUM_COLS / `VGA_NUM_ROWS as defaults for NUM_COLS/NUM_ROWS, and a phase_t enum {PH_V0, PH_V1, PH_V2}.
- Sub-module prg_inflight: a parameterised slot-delay line carrying {issued, x, y}. It is reusable for other fixed-latency pipes.
- Registers use the existing ff_ar flop primitive.

Test Plan:
- NUM_COLS=4, NUM_ROWS=2, PL_SLOTS=3, CREDITS=16; start pulse with ray_deq tied high -> 8 issues in consecutive slots, x/y order (0,0)..(3,1). ray_valid pulses at v0 exactly 9 cycles after each issue's v0, with matching ray_x/ray_y. frame_done pulses once. busy falls with it.
- Same config, CREDITS=2, ray_deq held low -> exactly 2 issues, then phases keep rotating with x/y frozen. Assert ray_deq for one cycle -> exactly one further issue at the next slot.
- ray_deq coincident with an issue at credits=1 -> credits stays 1 and issue continues next slot. ray_deq at credits==CREDITS -> credit_err=1 and stays 1.
- Assert rst mid-RUN after 3 issues -> next cycle all outputs at reset values and credits=CREDITS. No ray_valid or frame_done follows. A fresh start restarts at (0,0).
- start pulsed during RUN and during DRAIN -> ignored: no coordinate reset and exactly 8 ray_valid pulses total.
- Phase check: from reset, v0/v1/v2 remain one-hot and rotate every cycle for 30 cycles in IDLE, RUN and DRAIN.
